// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache refill controller.
//   slave  : the cache's view. It takes the PC, fetch and invalidate requests and
//            the memory ack/data, and drives the instruction, miss, req and addr outputs.
//   master : the view of the surrounding pipeline and memory model.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_PC;
  logic              i_Fetch_En;
  logic              i_Invalidate;
  logic [DATA_W-1:0] o_Instr;
  logic              o_ICache_Miss;
  logic              o_Mem_Req;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic              i_Mem_Ack;
  logic [DATA_W-1:0] i_Mem_Data;

  modport slave (
    input  i_PC, i_Fetch_En, i_Invalidate, i_Mem_Ack, i_Mem_Data,
    output o_Instr, o_ICache_Miss, o_Mem_Req, o_Mem_Addr
  );

  modport master (
    output i_PC, i_Fetch_En, i_Invalidate, i_Mem_Ack, i_Mem_Data,
    input  o_Instr, o_ICache_Miss, o_Mem_Req, o_Mem_Addr
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache for the IF stage, with a word-by-word refill controller.
// A hit returns the instruction in the same cycle. A miss raises o_ICache_Miss to the
// stall unit, then refills the whole line over a req/ack handshake on the memory side.
// Ports:
//   i_Clk, i_Reset : clock (rising edge) and asynchronous active-high reset
//   bus (slave)    : i_PC, i_Fetch_En, i_Invalidate, o_Instr, o_ICache_Miss,
//                    o_Mem_Req, o_Mem_Addr, i_Mem_Ack, i_Mem_Data
module icache_refill_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input logic                 i_Clk,
  input logic                 i_Reset,
  icache_refill_ctrl_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = ADDR_W - 2 - OFF_W;   // {tag,index} bits of a line address
  localparam int TAG_W  = LINE_W - IDX_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   line_q;      // line being refilled, as {tag,index}
  logic                abort_q;     // invalidated during refill: do not validate the line
  logic [NUM_LINES-1:0] valid_q;

  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_W-1:0] data_mem [NUM_LINES*LINE_WORDS];

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx, ref_idx;
  logic [TAG_W-1:0] pc_tag, ref_tag;
  logic             hit, ack, last, start, miss;
  logic             unused_pc_lsb;

  assign pc_off        = bus.i_PC[2 +: OFF_W];
  assign pc_idx        = bus.i_PC[2+OFF_W +: IDX_W];
  assign pc_tag        = bus.i_PC[ADDR_W-1 -: TAG_W];
  assign unused_pc_lsb = ^bus.i_PC[1:0];
  assign ref_idx       = line_q[IDX_W-1:0];
  assign ref_tag       = line_q[LINE_W-1 -: TAG_W];

  assign hit   = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  // An ack only counts while a request is outstanding.
  assign ack   = bus.i_Mem_Ack && (state_q == REFILL);
  assign last  = (cnt_q == OFF_W'(LINE_WORDS-1));
  // An invalidate wins over a miss in IDLE. The fetch stalls for this cycle and is looked up again next cycle.
  assign start = (state_q == IDLE) && bus.i_Fetch_En && !hit && !bus.i_Invalidate;

  always_comb begin
    state_d = state_q;
    miss    = 1'b0;
    case (state_q)
      IDLE: begin
        miss = bus.i_Fetch_En && (!hit || bus.i_Invalidate);
        if (start) state_d = REFILL;
      end
      REFILL: begin
        miss = 1'b1;
        if (ack && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      abort_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        line_q          <= {pc_tag, pc_idx};
        cnt_q           <= '0;
        valid_q[pc_idx] <= 1'b0;
      end
      if (ack) begin
        cnt_q <= cnt_q + OFF_W'(1);
        if (last && !abort_q) valid_q[ref_idx] <= 1'b1;
      end
      // Invalidate is applied last so that it overrides a line completing in the same cycle.
      if (bus.i_Invalidate) valid_q <= '0;
      if (ack && last)
        abort_q <= 1'b0;
      else if ((state_q == REFILL) && bus.i_Invalidate)
        abort_q <= 1'b1;
    end
  end

  // Tag and data storage have no reset. They are only trusted through valid_q.
  always_ff @(posedge i_Clk) begin
    if (ack) begin
      data_mem[{ref_idx, cnt_q}] <= bus.i_Mem_Data;
      if (last) tag_mem[ref_idx] <= ref_tag;
    end
  end

  assign bus.o_ICache_Miss = miss && !i_Reset;
  assign bus.o_Instr       = i_Reset ? '0 : data_mem[{pc_idx, pc_off}];
  assign bus.o_Mem_Req     = (state_q == REFILL);
  // The base address is line aligned, so the word address is just the count spliced in.
  assign bus.o_Mem_Addr    = {line_q, cnt_q, 2'b00};
endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .NUM_LINES(16)) dut (
    .i_Clk(clk), .i_Reset(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        fetch, inval, ack;
    logic [31:0] data;
    logic        miss, req;
    logic [31:0] addr;
    logic        chk_instr;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic [31:0] pc, logic fetch, logic inval, logic ack, logic [31:0] data,
                              logic miss, logic req, logic [31:0] addr, logic ci, logic [31:0] instr);
    vec_t v;
    v.pc = pc; v.fetch = fetch; v.inval = inval; v.ack = ack; v.data = data;
    v.miss = miss; v.req = req; v.addr = addr; v.chk_instr = ci; v.instr = instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic f, input logic inv, input logic a, input logic [31:0] d);
    bus.i_PC = pc; bus.i_Fetch_En = f; bus.i_Invalidate = inv; bus.i_Mem_Ack = a; bus.i_Mem_Data = d;
    #4;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // Cold fill of line 0x40 with back-to-back acks, then hits in the same line
    vecs.push_back(mk(32'h40, 1, 0, 0, 0,     1, 0, 0,     0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hA0,  1, 1, 'h40,  0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hA1,  1, 1, 'h44,  0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hA2,  1, 1, 'h48,  0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hA3,  1, 1, 'h4C,  0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 0, 0,     0, 0, 0,     1, 'hA0));
    vecs.push_back(mk(32'h48, 1, 0, 0, 0,     0, 0, 0,     1, 'hA2));
    // Conflicting line 0x440 (same index 4) replaces it
    vecs.push_back(mk(32'h440, 1, 0, 0, 0,    1, 0, 0,     0, 0));
    vecs.push_back(mk(32'h440, 1, 0, 1, 'hB0, 1, 1, 'h440, 0, 0));
    vecs.push_back(mk(32'h440, 1, 0, 1, 'hB1, 1, 1, 'h444, 0, 0));
    vecs.push_back(mk(32'h440, 1, 0, 1, 'hB2, 1, 1, 'h448, 0, 0));
    vecs.push_back(mk(32'h440, 1, 0, 1, 'hB3, 1, 1, 'h44C, 0, 0));
    vecs.push_back(mk(32'h440, 1, 0, 0, 0,    0, 0, 0,     1, 'hB0));
    vecs.push_back(mk(32'h44C, 1, 0, 0, 0,    0, 0, 0,     1, 'hB3));
    // Going back to 0x40 misses again
    vecs.push_back(mk(32'h40, 1, 0, 0, 0,     1, 0, 0,     0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hC0,  1, 1, 'h40,  0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hC1,  1, 1, 'h44,  0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hC2,  1, 1, 'h48,  0, 0));
    vecs.push_back(mk(32'h40, 1, 0, 1, 'hC3,  1, 1, 'h4C,  0, 0));
    vecs.push_back(mk(32'h4C, 1, 0, 0, 0,     0, 0, 0,     1, 'hC3));
    // A stray ack with no request is ignored
    vecs.push_back(mk(32'h4C, 1, 0, 1, 'hDEAD, 0, 0, 0,    1, 'hC3));
    vecs.push_back(mk(32'h4C, 1, 0, 0, 0,     0, 0, 0,     1, 'hC3));
    // A missing PC without fetch enable does not miss
    vecs.push_back(mk(32'h80, 0, 0, 0, 0,     0, 0, 0,     0, 0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("reset_miss", {31'd0, bus.o_ICache_Miss}, 0);
    chk("reset_req",  {31'd0, bus.o_Mem_Req}, 0);
    chk("reset_addr", bus.o_Mem_Addr, 0);
    chk("reset_instr", bus.o_Instr, 0);
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pc, vecs[i].fetch, vecs[i].inval, vecs[i].ack, vecs[i].data);
      chk($sformatf("v%0d_miss", i), {31'd0, bus.o_ICache_Miss}, {31'd0, vecs[i].miss});
      chk($sformatf("v%0d_req", i),  {31'd0, bus.o_Mem_Req}, {31'd0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), bus.o_Mem_Addr, vecs[i].addr);
      if (vecs[i].chk_instr) chk($sformatf("v%0d_instr", i), bus.o_Instr, vecs[i].instr);
      tick();
    end

    // Slow memory: two idle cycles before every ack, address held until its ack
    drive(32'h100, 1, 0, 0, 0);
    chk("slow_detect_miss", {31'd0, bus.o_ICache_Miss}, 1);
    tick();
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < 2; g++) begin
        drive(32'h100, 1, 0, 0, 0);
        chk($sformatf("slow_w%0d_g%0d_miss", w, g), {31'd0, bus.o_ICache_Miss}, 1);
        chk($sformatf("slow_w%0d_g%0d_req", w, g),  {31'd0, bus.o_Mem_Req}, 1);
        chk($sformatf("slow_w%0d_g%0d_addr", w, g), bus.o_Mem_Addr, 32'h100 + 4*w);
        tick();
      end
      drive(32'h100, 1, 0, 1, 32'h5000_0000 + w);
      chk($sformatf("slow_w%0d_ack_addr", w), bus.o_Mem_Addr, 32'h100 + 4*w);
      chk($sformatf("slow_w%0d_ack_miss", w), {31'd0, bus.o_ICache_Miss}, 1);
      tick();
    end
    for (int w = 0; w < 4; w++) begin
      drive(32'h100 + 4*w, 1, 0, 0, 0);
      chk($sformatf("slow_hit%0d_miss", w), {31'd0, bus.o_ICache_Miss}, 0);
      chk($sformatf("slow_hit%0d_instr", w), bus.o_Instr, 32'h5000_0000 + w);
      tick();
    end

    // Invalidate in IDLE: stalls but starts no refill that cycle
    drive(32'h40, 1, 1, 0, 0);
    chk("inv_idle_miss", {31'd0, bus.o_ICache_Miss}, 1);
    tick();
    drive(32'h40, 1, 0, 0, 0);
    chk("inv_idle_norefill_req", {31'd0, bus.o_Mem_Req}, 0);
    chk("inv_idle_remiss", {31'd0, bus.o_ICache_Miss}, 1);
    tick();
    // Refill of 0x40 with an invalidate pulse after the 2nd ack
    drive(32'h40, 1, 0, 1, 'hD0); tick();
    drive(32'h40, 1, 0, 1, 'hD1); tick();
    drive(32'h40, 1, 1, 0, 0);
    chk("inv_mid_req", {31'd0, bus.o_Mem_Req}, 1);
    chk("inv_mid_addr", bus.o_Mem_Addr, 32'h48);
    tick();
    drive(32'h40, 1, 0, 1, 'hD2); tick();
    drive(32'h40, 1, 0, 1, 'hD3); tick();
    drive(32'h40, 1, 0, 0, 0);
    chk("inv_after_miss", {31'd0, bus.o_ICache_Miss}, 1);
    chk("inv_after_req",  {31'd0, bus.o_Mem_Req}, 0);
    tick();
    drive(32'h40, 1, 0, 0, 0);
    chk("inv_new_req",  {31'd0, bus.o_Mem_Req}, 1);
    chk("inv_new_addr", bus.o_Mem_Addr, 32'h40);
    tick();
    for (int w = 0; w < 4; w++) begin
      drive(32'h40, 1, 0, 1, 32'hE0 + w); tick();
    end
    drive(32'h44, 1, 0, 0, 0);
    chk("inv_refill_hit_miss", {31'd0, bus.o_ICache_Miss}, 0);
    chk("inv_refill_hit_instr", bus.o_Instr, 32'hE1);
    tick();

    // Reset in the middle of a refill
    drive(32'h300, 1, 0, 0, 0);
    chk("rst_mid_detect", {31'd0, bus.o_ICache_Miss}, 1);
    tick();
    drive(32'h300, 1, 0, 1, 'hF0);
    chk("rst_mid_req_before", {31'd0, bus.o_Mem_Req}, 1);
    tick();
    bus.i_Mem_Ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_req",   {31'd0, bus.o_Mem_Req}, 0);
    chk("rst_mid_miss",  {31'd0, bus.o_ICache_Miss}, 0);
    chk("rst_mid_instr", bus.o_Instr, 0);
    tick();
    rst = 1'b0;
    drive(32'h40, 1, 0, 0, 0);
    chk("rst_after_miss", {31'd0, bus.o_ICache_Miss}, 1);
    chk("rst_after_req",  {31'd0, bus.o_Mem_Req}, 0);
    tick();
    drive(32'h40, 1, 0, 0, 0);
    chk("rst_after_refill_addr", bus.o_Mem_Addr, 32'h40);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Direct-mapped instruction cache with refill controller, in the IF stage.
- Looks up the current PC and returns the instruction on a hit.
- On a miss, raises o_ICache_Miss to the stall unit. That freezes the PC and flushes IFID.
- Refills the line word-by-word from the memory side over a req/ack handshake, then releases the miss.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, instruction word width
LINE_WORDS, 4, words per line (power of 2, >=2)
NUM_LINES, 16, cache lines (power of 2)

Ports:
i_Clk  input  1  clock, rising edge
i_Reset  input  1  asynchronous, active-high reset
i_PC  input  ADDR_W  fetch byte address, word aligned (bits [1:0] ignored)
i_Fetch_En  input  1  fetch request this cycle
i_Invalidate  input  1  invalidate entire cache
o_Instr  output  DATA_W  instruction at i_PC; valid when i_Fetch_En && !o_ICache_Miss
o_ICache_Miss  output  1  to stall unit
o_Mem_Req  output  1  refill word request
o_Mem_Addr  output  ADDR_W  refill word byte address
i_Mem_Ack  input  1  i_Mem_Data valid and request accepted
i_Mem_Data  input  DATA_W  refill word

Behaviour:
- Address split: offset = PC[2 +: log2(LINE_WORDS)], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Storage: valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES*LINE_WORDS].
  - Combinational read.
  - Only valid bits are reset.
- Hit = valid[index] && tag[index]==tag(i_PC).
  - o_Instr = data[index][offset] in the same cycle (zero-latency hit).
- FSM states: IDLE, REFILL.
- Reset (async): state=IDLE, word count=0, all valid=0, o_Mem_Req=0, o_Mem_Addr=0, abort flag=0. o_ICache_Miss=0 and o_Instr=0 while i_Reset is high.
- o_ICache_Miss = (IDLE && i_Fetch_En && !hit) || REFILL.
  - Combinational.
  - Asserted in the detection cycle.
- IDLE, i_Fetch_En && !hit && !i_Invalidate:
  - Latch line base = {tag,index,0...}.
  - Clear valid[index], count=0, go REFILL.
  - o_Mem_Req=1 and o_Mem_Addr=base from the next cycle.
- REFILL handshake:
  - o_Mem_Req held 1; o_Mem_Addr = base + 4*count, stable until ack.
  - On i_Mem_Ack: write i_Mem_Data to data[idx][count], count++, address advances next edge.
  - Back-to-back acks (one per cycle) are legal; gaps of any length are legal.
- Last ack (count==LINE_WORDS-1):
  - Write tag; set valid unless the abort flag is set.
  - Go IDLE with o_Mem_Req=0.
  - Next cycle the lookup hits, so the miss drops.
  - Minimum miss penalty = 1 detect cycle + LINE_WORDS ack cycles.
- i_Mem_Ack while o_Mem_Req=0: ignored.
- i_PC and i_Fetch_En changes during REFILL:
  - Ignored for the refill, which completes on the latched base.
  - The hit after return to IDLE is evaluated on the then-current i_PC; a different missing line starts a new refill.
- i_Invalidate:
  - In IDLE: clears all valid bits at the edge. No refill starts that cycle; o_ICache_Miss = i_Fetch_En.
  - In REFILL: clears all valid and sets the abort flag. The refill runs to completion but does not set valid, so the line re-misses. The abort flag clears on return to IDLE.
- Reset mid-refill: o_Mem_Req drops immediately; partial line discarded (valid already 0).
- Counter width: log2(LINE_WORDS) bits.
- Address arithmetic wraps at ADDR_W; base is line-aligned, so no carry into the index.

Test Plan:
- Cold miss: reset, i_PC=0x40, fetch on; memory acks every cycle with data 0xA0..0xA3.
  - o_Mem_Addr sequence must be 0x40,0x44,0x48,0x4C.
  - o_ICache_Miss is high for 5 cycles, then low.
  - o_Instr=0xA0.
- Hit, same line: i_PC=0x48 after the fill -> o_ICache_Miss=0 in the same cycle, o_Instr=0xA2, no o_Mem_Req.
- Conflict: i_PC=0x440 (index 4, new tag), fill data 0xB0..0xB3 -> refill replaces the line.
  - Return to 0x40 -> miss and refill again.
- Slow memory: acks with 2-cycle gaps.
  - o_Mem_Addr must hold each value until its ack.
  - Miss must stay high throughout.
  - Words must be stored in order.
- Invalidate mid-refill: pulse i_Invalidate after the 2nd ack.
  - Refill completes (4 acks).
  - Next cycle o_ICache_Miss=1 and a new refill starts at 0x40.
- Reset mid-refill: assert i_Reset after the 1st ack.
  - o_Mem_Req=0 and o_ICache_Miss=0 immediately.
  - After release, fetch at 0x40 misses.
